des_byte_host: RTL

Host-side driver for the DES core's block handshake. It packs an incoming byte stream into 64-bit blocks and presents each block to the core with a one-cycle start strobe. It waits for the core's completion pulse, captures the 64-bit result, and streams it back out as bytes. It sits between a byte-wide valid/ready source/sink (UART or bus bridge) and the DES core's data_in/ready/ed_sel/data_out/next_data ports.

---
 rtl/des_byte_host.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/des_byte_host.sv
// des_byte_host: packs a byte stream into 64-bit blocks for a DES core,
// issues a one-cycle start strobe, waits (with timeout) for the completion
// pulse, captures the result and streams it back out MSB byte first.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready     byte input stream (valid/ready)
//   ed_mode           encrypt/decrypt select, sampled with the first byte
//   out_data/out_valid/out_ready  byte output stream (valid/ready)
//   des_data_in/des_ready/des_ed_sel  block, start strobe and mode to core
//   des_data_out/des_next_data        core result and completion pulse
//   err/clr_err       sticky timeout flag and its clear
//   blocks_done       wrapping count of fully drained blocks
module des_byte_host #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ed_mode,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] des_data_in,
  output logic        des_ready,
  output logic        des_ed_sel,
  input  logic [63:0] des_data_out,
  input  logic        des_next_data,
  output logic        err,
  input  logic        clr_err,
  output logic [15:0] blocks_done
);

  localparam int unsigned BlkW  = 64;
  localparam int unsigned ByteW = 8;
  localparam int unsigned IdxW  = 3;
  localparam int unsigned CntW  = 16;

  typedef enum logic [1:0] {
    S_FILL,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BlkW-1:0]   blk_q, blk_d;
  logic [BlkW-1:0]   res_q, res_d;
  logic              ed_q, ed_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   blocks_done_q, blocks_done_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              des_ready_q, des_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout;
  logic [CntW:0]     cnt_inc;

  // One extra bit so TIMEOUT_CYCLES up to 65535 compares without wrap.
  assign cnt_inc = {1'b0, cnt_q} + (CntW+1)'(1);

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    blk_d         = blk_q;
    res_d         = res_q;
    ed_d          = ed_q;
    cnt_d         = cnt_q;
    blocks_done_d = blocks_done_q;
    timeout       = 1'b0;

    case (state_q)
      S_FILL: begin
        // in_ready_q is only ever high in FILL, and stays low for the first
        // cycle after reset.
        if (in_valid && in_ready_q) begin
          blk_d = {blk_q[BlkW-ByteW-1:0], in_data};
          if (idx_q == '0) begin
            ed_d = ed_mode;
          end
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxW'(7)) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        // Completion beats a simultaneous timeout.
        if (des_next_data) begin
          res_d   = des_data_out;
          state_d = S_DRAIN;
        end else if (cnt_inc == (CntW+1)'(TIMEOUT_CYCLES)) begin
          timeout = 1'b1;
          idx_d   = '0;
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          res_d = {res_q[BlkW-ByteW-1:0], ByteW'(0)};
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxW'(7)) begin
            blocks_done_d = blocks_done_q + CntW'(1);
            idx_d         = '0;
            state_d       = S_FILL;
          end
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    // Set beats clear.
    if (timeout) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    in_ready_d  = (state_d == S_FILL);
    des_ready_d = (state_d == S_START);
    out_valid_d = (state_d == S_DRAIN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FILL;
      idx_q         <= '0;
      blk_q         <= '0;
      res_q         <= '0;
      ed_q          <= 1'b0;
      cnt_q         <= '0;
      blocks_done_q <= '0;
      err_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      des_ready_q   <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      blk_q         <= blk_d;
      res_q         <= res_d;
      ed_q          <= ed_d;
      cnt_q         <= cnt_d;
      blocks_done_q <= blocks_done_d;
      err_q         <= err_d;
      in_ready_q    <= in_ready_d;
      des_ready_q   <= des_ready_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = res_q[BlkW-1 -: ByteW];
  assign out_valid   = out_valid_q;
  assign des_data_in = blk_q;
  assign des_ready   = des_ready_q;
  assign des_ed_sel  = ed_q;
  assign err         = err_q;
  assign blocks_done = blocks_done_q;

endmodule
